// File: rtl/systolic_result_drain_if.sv
// Result stream from the systolic drain toward the result sink (DMA / SRAM writer).
// A beat moves on valid && ready; row/col locate the element inside the tile.
interface systolic_result_drain_if #(
  parameter int DATA_W = 16,
  parameter int RC_W   = 4
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [RC_W-1:0]   row;
  logic [RC_W-1:0]   col;
  logic              last;

  modport master (output valid, data, row, col, last, input  ready);
  modport slave  (input  valid, data, row, col, last, output ready);
endinterface

// File: rtl/systolic_result_drain.sv
// Waits out the array settle latency, snapshots the C matrix, then streams it row-major.
// The snapshot frees the array for its next tile as soon as capture is done.
//
// state   | meaning
// IDLE    | waiting for start
// WAIT    | settle timer running, 0..SETTLE-1
// CAPTURE | c_flat registered into the snapshot
// STREAM  | emitting snapshot elements, one per accepted beat
// DONE_ST | one-cycle done pulse, then back to IDLE
module systolic_result_drain #(
  parameter int N      = 16,
  parameter int DATA_W = 16,
  parameter int SETTLE = 46
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N*N*DATA_W-1:0]   c_flat,
  output logic                    busy,
  output logic                    snap_done,
  output logic                    done,
  systolic_result_drain_if.master res
);

  localparam int RC_W  = $clog2(N);
  localparam int IDX_W = 2 * RC_W;
  localparam int NUM   = N * N;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    CAPTURE = 3'd2,
    STREAM  = 3'd3,
    DONE_ST = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [N*N*DATA_W-1:0] snap;
  logic                  snap_done_q;
  logic                  settle_tc;
  logic                  xfer;
  logic                  last_idx;

  assign settle_tc = (cnt == CNT_W'(SETTLE - 1));
  assign xfer      = (state == STREAM) && res.ready;
  assign last_idx  = (idx == IDX_W'(NUM - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      snap_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      snap_done_q <= (state == CAPTURE);
      if (state == WAIT && !settle_tc) cnt <= cnt + 1'b1;
      else                             cnt <= '0;
      // idx spans exactly N*N values, so the final increment wraps it to 0
      if (xfer) idx <= idx + 1'b1;
    end
  end

  // Snapshot is never reset: its contents are only observed after a capture.
  always_ff @(posedge clk) begin
    if (state == CAPTURE) snap <= c_flat;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)            state_nxt = WAIT;
      WAIT:    if (settle_tc)        state_nxt = CAPTURE;
      CAPTURE:                       state_nxt = STREAM;
      STREAM:  if (xfer && last_idx) state_nxt = DONE_ST;
      DONE_ST:                       state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE_ST);
  assign snap_done = snap_done_q;

  assign res.valid = (state == STREAM);
  assign res.data  = res.valid ? snap[idx*DATA_W +: DATA_W] : '0;
  assign res.row   = idx[IDX_W-1:RC_W];
  assign res.col   = idx[RC_W-1:0];
  assign res.last  = res.valid && last_idx;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: latency, streaming, backpressure,
// snapshot isolation, ignored starts, async abort and boundary data.
module tb_systolic_result_drain;

  localparam int N      = 16;
  localparam int DATA_W = 16;
  localparam int SETTLE = 46;
  localparam int NUM    = N * N;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  start = 1'b0;
  logic [NUM*DATA_W-1:0] c_flat = '0;
  logic                  busy, snap_done, done;

  logic [DATA_W-1:0] exp_mem [NUM];
  int n_vec = 0;
  int n_err = 0;
  int lat;
  int stream_cyc;

  systolic_result_drain_if #(.DATA_W(DATA_W), .RC_W(4)) res_if ();

  systolic_result_drain #(.N(N), .DATA_W(DATA_W), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .c_flat    (c_flat),
    .busy      (busy),
    .snap_done (snap_done),
    .done      (done),
    .res       (res_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cflat();
    for (int k = 0; k < NUM; k++) c_flat[k*DATA_W +: DATA_W] = exp_mem[k];
  endtask

  // Pulse start, then wait for snap_done; optionally re-pulse start mid-WAIT.
  task automatic start_and_wait(input int inject_at);
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (!snap_done && lat < 200) begin
      chk("busy_wait", busy, 1);
      start = (lat == inject_at);
      step();
      lat++;
    end
    start = 1'b0;
    chk("snap_lat", lat, SETTLE + 1);
    chk("valid_at_snap", res_if.valid, 1);
  endtask

  task automatic drain(input bit bp, input int start_at, input int abort_at);
    int beats = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [DATA_W-1:0] pd = '0;
    logic [3:0] pr = '0, pc = '0;
    logic pl = 1'b0;
    while (beats < NUM && cyc < 3000) begin
      if (beats == abort_at) begin
        rst = 1'b0;
        #1;
        chk("abort_valid", res_if.valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        return;
      end
      start = (cyc == start_at);
      chk("valid", res_if.valid, 1);
      chk("busy_stream", busy, 1);
      if (stalled) begin
        chk("hold_data", res_if.data, pd);
        chk("hold_row", res_if.row, pr);
        chk("hold_col", res_if.col, pc);
        chk("hold_last", res_if.last, pl);
      end
      res_if.ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (res_if.ready) begin
        chk("data", res_if.data, exp_mem[beats]);
        chk("row", res_if.row, beats / N);
        chk("col", res_if.col, beats % N);
        chk("last", res_if.last, beats == NUM - 1);
        beats++;
        stalled = 0;
      end else begin
        stalled = 1;
        pd = res_if.data; pr = res_if.row; pc = res_if.col; pl = res_if.last;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    stream_cyc = cyc;
    if (beats < NUM) chk("drain_timeout", beats, NUM);
    chk("done_pulse", done, 1);
    chk("valid_fall", res_if.valid, 0);
    step();
    chk("done_clear", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic idle_check(input string tag);
    for (int i = 0; i < 5; i++) begin
      step();
      chk(tag, busy, 0);
    end
  endtask

  initial begin
    res_if.ready = 1'b0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_if.valid, 0);
    chk("rst_done", done, 0);
    chk("rst_snap", snap_done, 0);
    chk("rst_last", res_if.last, 0);
    chk("rst_data", res_if.data, 0);
    chk("rst_row", res_if.row, 0);
    chk("rst_col", res_if.col, 0);
    rst = 1'b1;
    step();
    res_if.ready = 1'b1;
    step();
    chk("ready_idle_valid", res_if.valid, 0);

    // full tile, ready held high: back-to-back beats
    for (int k = 0; k < NUM; k++) exp_mem[k] = DATA_W'(k * 3);
    load_cflat();
    start_and_wait(-1);
    drain(1'b0, -1, -1);
    chk("b2b_cycles", stream_cyc, NUM);
    idle_check("idle_after1");

    // backpressure 1,0,0,1
    start_and_wait(-1);
    drain(1'b1, -1, -1);
    idle_check("idle_after_bp");

    // snapshot isolation: overwrite c_flat one cycle after capture
    start_and_wait(-1);
    c_flat = '1;
    drain(1'b0, -1, -1);
    load_cflat();
    step();

    // start during WAIT and during STREAM is ignored
    start_and_wait(10);
    drain(1'b1, 50, -1);
    idle_check("no_queue");

    // async abort at beat 100, then a clean restart
    start_and_wait(-1);
    drain(1'b0, -1, 100);
    step();
    chk("abort_hold_busy", busy, 0);
    chk("abort_hold_done", done, 0);
    rst = 1'b1;
    step();
    res_if.ready = 1'b1;
    start_and_wait(-1);
    chk("restart_row", res_if.row, 0);
    chk("restart_col", res_if.col, 0);
    drain(1'b0, -1, -1);

    // boundary: only (15,15) non-zero
    for (int k = 0; k < NUM; k++) exp_mem[k] = '0;
    exp_mem[NUM-1] = 16'hFFFF;
    load_cflat();
    start_and_wait(-1);
    drain(1'b0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Read-side counterpart to the 16x16 systolic array's C output.
- After the host issues start, the block waits a fixed settle latency, then snapshots the array's flattened C matrix.
- It streams the snapshot out one element per handshake, in row-major order, over a valid/ready interface toward the result sink (DMA/host SRAM writer).
- The array can begin the next tile as soon as the snapshot is taken.

Parameters:
- N, 16, array dimension (N x N PEs); must be a power of two.
- DATA_W, 16, width of each C element.
- SETTLE, 46, cycles from start to capture (3*N-2 for N=16); must be at least 1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to drain the current tile; honoured only in IDLE.
- c_flat  input  N*N*DATA_W  array outputs; element (r,c) at bits [(r*N+c)*DATA_W +: DATA_W].
- busy  output  1  high in every state except IDLE.
- snap_done  output  1  one-cycle pulse in the cycle after capture; array may be reused.
- out_valid  output  1  stream data valid.
- out_ready  input  1  sink ready.
- out_data  output  DATA_W  element value.
- out_row  output  log2(N)  row index of out_data.
- out_col  output  log2(N)  column index of out_data.
- out_last  output  1  high with element (N-1,N-1).
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (rst low, asynchronous): FSM to IDLE; counters cleared; busy, snap_done, out_valid, out_last, done = 0; out_data, out_row, out_col = 0; snapshot contents need not be cleared.
- States:
  - IDLE -> WAIT on start=1.
  - WAIT: counter runs 0..SETTLE-1; when count == SETTLE-1 -> CAPTURE.
  - CAPTURE: one cycle; all N*N elements of c_flat registered into the snapshot; -> STREAM; snap_done pulses the next cycle.
  - STREAM: emits elements, then -> DONE_ST when the last beat is accepted.
  - DONE_ST: one cycle, done=1; -> IDLE.
- Latency:
  - start sampled at edge t; capture edge at t+SETTLE+1.
  - First out_valid=1 in the cycle after capture; snap_done=1 in that same cycle.
- Stream rules:
  - A beat transfers when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last must hold stable, and out_valid must not drop.
  - Index idx (log2(N*N) bits) increments only on transfer; out_row = idx[MSBs], out_col = idx[LSBs].
  - out_valid stays high across back-to-back transfers: throughput is 1 beat/cycle with out_ready held high, so N*N cycles for a full tile.
  - out_last=1 exactly when idx == N*N-1.
  - On the last transfer, idx wraps to 0, out_valid falls the next cycle, and the FSM enters DONE_ST.
- out_ready asserted while out_valid=0: no effect.
- start while busy: ignored, no queueing. start in the same cycle as done: ignored, because the block is not yet in IDLE.
- c_flat changes after capture: no effect on the streamed data.
- Reset mid-WAIT or mid-STREAM: immediate abort to IDLE; no done pulse; the partial stream is dropped.
- No arithmetic on data; values pass through bit-exact, unsigned and untruncated.

Test Plan:
- Reset, then start, with c_flat element k = k*3, out_ready=1 -> snap_done in cycle 48 after start; 256 consecutive beats; beat k has out_data=3k, row=k/16, col=k%16; out_last only on beat 255 (data 765); done one cycle later.
- Backpressure: out_ready toggles 1,0,0,1 repeating -> outputs stable during stalls, no lost or duplicated beats, 256 beats total, done after the final accept.
- Snapshot isolation: change c_flat to all 0xFFFF one cycle after capture -> the stream still carries the pre-capture values.
- start pulsed during WAIT and during STREAM -> ignored; exactly one 256-beat stream; busy held high throughout.
- Assert rst low asynchronously mid-STREAM at beat 100 -> out_valid, busy and done go 0 immediately; after release, a new start gives a complete stream beginning at row 0, col 0.
- Boundary value: element (15,15)=0xFFFF, all others 0x0000 -> last beat carries 0xFFFF with out_last=1; all earlier beats are 0 with out_last=0.
